// File: rtl/cu_pkg.sv
// Shared types and encodings for the parametrised 301 RISC control unit.
package cu_pkg;

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXEC    = 3'd3,
    ST_HALT    = 3'd4,
    ST_ILLEGAL = 3'd5
  } state_e;

  localparam logic [6:0] OP_ADD  = 7'h70;
  localparam logic [6:0] OP_SUB  = 7'h71;
  localparam logic [6:0] OP_CMP  = 7'h72;
  localparam logic [6:0] OP_MOV  = 7'h73;
  localparam logic [6:0] OP_SHL  = 7'h74;
  localparam logic [6:0] OP_SHR  = 7'h75;
  localparam logic [6:0] OP_INC  = 7'h76;
  localparam logic [6:0] OP_DEC  = 7'h77;
  localparam logic [6:0] OP_LD   = 7'h78;
  localparam logic [6:0] OP_STO  = 7'h79;
  localparam logic [6:0] OP_LDI  = 7'h7A;
  localparam logic [6:0] OP_HALT = 7'h7B;
  localparam logic [6:0] OP_JE   = 7'h7C;
  localparam logic [6:0] OP_JNE  = 7'h7D;
  localparam logic [6:0] OP_JC   = 7'h7E;
  localparam logic [6:0] OP_JMP  = 7'h7F;

  localparam logic [3:0] ALU_PASS = 4'b0000;
  localparam logic [3:0] ALU_INC  = 4'b0010;
  localparam logic [3:0] ALU_DEC  = 4'b0011;
  localparam logic [3:0] ALU_ADD  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0101;
  localparam logic [3:0] ALU_SHR  = 4'b0110;
  localparam logic [3:0] ALU_SHL  = 4'b0111;

  typedef struct packed {
    logic       adr_sel;
    logic       s_sel;
    logic       pc_ld;
    logic       pc_inc;
    logic       pc_sel;
    logic       ir_ld;
    logic       mw_en;
    logic       rw_en;
    logic [3:0] alu_op;
    logic       mem_req;
    logic       halted;
    logic       illegal;
    logic [7:0] status;
  } ctrl_t;

  function automatic int cu_iw(input int raw);
    return 7 + 3 * raw;
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational decode: state, instruction, flags and memory ready -> control word and next state.
//
// state      | meaning
// RESET      | post-reset idle cycle, LEDs all on
// FETCH      | read instruction, wait for mem_rdy
// DECODE     | classify opcode
// EXEC       | one cycle per op; memory ops wait for mem_rdy
// HALT       | resumable stop, leave on go
// ILLEGAL    | sticky trap, leave only through reset
module cu_decode
  import cu_pkg::*;
#(
  parameter int RAW = 3,
  parameter int OPW = 7,
  parameter int IW  = cu_iw(RAW)
) (
  input  state_e           state_i,
  input  logic [IW-1:0]    ir_i,
  input  logic [2:0]       flags_i,
  input  logic             mem_rdy_i,
  input  logic             go_i,
  output ctrl_t            ctrl_o,
  output logic [RAW-1:0]   w_adr_o,
  output logic [RAW-1:0]   r_adr_o,
  output logic [RAW-1:0]   s_adr_o,
  output state_e           next_o,
  output logic             flag_ld_o
);

  logic [6:0]     op;
  logic [RAW-1:0] wf, rf, sf;

  assign op = 7'(ir_i[IW-1 -: OPW]);
  assign wf = ir_i[3*RAW-1 -: RAW];
  assign rf = ir_i[2*RAW-1 -: RAW];
  assign sf = ir_i[RAW-1:0];

  always_comb begin
    ctrl_o    = '0;
    w_adr_o   = '0;
    r_adr_o   = '0;
    s_adr_o   = '0;
    next_o    = ST_RESET;
    flag_ld_o = 1'b0;
    case (state_i)
      ST_RESET: begin
        ctrl_o.status = 8'hFF;
        next_o        = ST_FETCH;
      end
      ST_FETCH: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.status  = 8'h80;
        ctrl_o.ir_ld   = mem_rdy_i;
        ctrl_o.pc_inc  = mem_rdy_i;
        next_o         = mem_rdy_i ? ST_DECODE : ST_FETCH;
      end
      ST_DECODE: begin
        ctrl_o.status = 8'hC0;
        if (op == OP_HALT)        next_o = ST_HALT;
        else if (op[6:4] == 3'b111) next_o = ST_EXEC;
        else                      next_o = ST_ILLEGAL;
      end
      ST_EXEC: begin
        ctrl_o.status = {flags_i, 1'b0, op[3:0]};
        next_o        = ST_FETCH;
        w_adr_o       = wf;
        r_adr_o       = rf;
        s_adr_o       = sf;
        case (op)
          OP_ADD: begin ctrl_o.alu_op = ALU_ADD; ctrl_o.rw_en = 1'b1; flag_ld_o = 1'b1; end
          OP_SUB: begin ctrl_o.alu_op = ALU_SUB; ctrl_o.rw_en = 1'b1; flag_ld_o = 1'b1; end
          OP_CMP: begin ctrl_o.alu_op = ALU_SUB; flag_ld_o = 1'b1; end
          OP_MOV: begin ctrl_o.alu_op = ALU_PASS; ctrl_o.rw_en = 1'b1; end
          OP_SHL: begin ctrl_o.alu_op = ALU_SHL; ctrl_o.rw_en = 1'b1; flag_ld_o = 1'b1; end
          OP_SHR: begin ctrl_o.alu_op = ALU_SHR; ctrl_o.rw_en = 1'b1; flag_ld_o = 1'b1; end
          OP_INC: begin ctrl_o.alu_op = ALU_INC; ctrl_o.rw_en = 1'b1; flag_ld_o = 1'b1; end
          OP_DEC: begin ctrl_o.alu_op = ALU_DEC; ctrl_o.rw_en = 1'b1; flag_ld_o = 1'b1; end
          OP_LD: begin
            r_adr_o        = sf;
            ctrl_o.adr_sel = 1'b1;
            ctrl_o.s_sel   = 1'b1;
            ctrl_o.mem_req = 1'b1;
            ctrl_o.rw_en   = mem_rdy_i;
            if (!mem_rdy_i) next_o = ST_EXEC;
          end
          OP_STO: begin
            r_adr_o        = wf;
            ctrl_o.adr_sel = 1'b1;
            ctrl_o.mem_req = 1'b1;
            ctrl_o.mw_en   = mem_rdy_i;
            if (!mem_rdy_i) next_o = ST_EXEC;
          end
          OP_LDI: begin
            // immediate sits in the word after the opcode, so PC steps past it
            ctrl_o.s_sel   = 1'b1;
            ctrl_o.mem_req = 1'b1;
            ctrl_o.rw_en   = mem_rdy_i;
            ctrl_o.pc_inc  = mem_rdy_i;
            if (!mem_rdy_i) next_o = ST_EXEC;
          end
          OP_JE:  ctrl_o.pc_ld = flags_i[1];
          OP_JNE: ctrl_o.pc_ld = ~flags_i[1];
          OP_JC:  ctrl_o.pc_ld = flags_i[0];
          OP_JMP: begin ctrl_o.pc_ld = 1'b1; ctrl_o.pc_sel = 1'b1; end
          default: ;
        endcase
      end
      ST_HALT: begin
        ctrl_o.halted = 1'b1;
        ctrl_o.status = {flags_i, 5'b01011};
        next_o        = go_i ? ST_FETCH : ST_HALT;
      end
      ST_ILLEGAL: begin
        ctrl_o.illegal = 1'b1;
        ctrl_o.status  = 8'hF0;
        next_o         = ST_ILLEGAL;
      end
      default: next_o = ST_RESET;
    endcase
  end

endmodule

// File: rtl/cu_param.sv
// Parametrised wait-state-aware control unit: state and flag registers around cu_decode.
module cu_param
  import cu_pkg::*;
#(
  parameter int RAW = 3,
  parameter int OPW = 7,
  localparam int IW = cu_iw(RAW)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [IW-1:0]  IR,
  input  logic           N,
  input  logic           Z,
  input  logic           C,
  input  logic           mem_rdy,
  input  logic           go,
  output logic [RAW-1:0] W_Adr,
  output logic [RAW-1:0] R_Adr,
  output logic [RAW-1:0] S_Adr,
  output logic           adr_sel,
  output logic           s_sel,
  output logic           pc_ld,
  output logic           pc_inc,
  output logic           pc_sel,
  output logic           ir_ld,
  output logic           mw_en,
  output logic           rw_en,
  output logic [3:0]     alu_op,
  output logic           mem_req,
  output logic           halted,
  output logic           illegal,
  output logic [7:0]     status
);

  state_e     state_q, state_d;
  logic [2:0] flags_q, flags_d;
  logic       flag_ld;
  ctrl_t      ctrl;

  cu_decode #(.RAW(RAW), .OPW(OPW), .IW(IW)) u_decode (
    .state_i   (state_q),
    .ir_i      (IR),
    .flags_i   (flags_q),
    .mem_rdy_i (mem_rdy),
    .go_i      (go),
    .ctrl_o    (ctrl),
    .w_adr_o   (W_Adr),
    .r_adr_o   (R_Adr),
    .s_adr_o   (S_Adr),
    .next_o    (state_d),
    .flag_ld_o (flag_ld)
  );

  assign flags_d = flag_ld ? {N, Z, C} : flags_q;

  // async clear drops mem_req/mw_en/rw_en immediately, abandoning any access in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RESET;
      flags_q <= 3'b000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  assign adr_sel = ctrl.adr_sel;
  assign s_sel   = ctrl.s_sel;
  assign pc_ld   = ctrl.pc_ld;
  assign pc_inc  = ctrl.pc_inc;
  assign pc_sel  = ctrl.pc_sel;
  assign ir_ld   = ctrl.ir_ld;
  assign mw_en   = ctrl.mw_en;
  assign rw_en   = ctrl.rw_en;
  assign alu_op  = ctrl.alu_op;
  assign mem_req = ctrl.mem_req;
  assign halted  = ctrl.halted;
  assign illegal = ctrl.illegal;
  assign status  = ctrl.status;

endmodule

// File: tb/tb_cu_param.sv
// Self-checking bench for cu_param: opcode table, hand-written corner sequences, random run vs. reference model.
module tb_cu_param;

  logic        clk, reset_n;
  logic [15:0] IR;
  logic [18:0] IR4;
  logic        N, Z, C, mem_rdy, go;

  logic [2:0] W_Adr, R_Adr, S_Adr;
  logic       adr_sel, s_sel, pc_ld, pc_inc, pc_sel, ir_ld, mw_en, rw_en;
  logic [3:0] alu_op;
  logic       mem_req, halted, illegal;
  logic [7:0] status;

  logic [3:0] W4, R4, S4;
  logic       adr_sel4, s_sel4, pc_ld4, pc_inc4, pc_sel4, ir_ld4, mw_en4, rw_en4;
  logic [3:0] alu_op4;
  logic       mem_req4, halted4, illegal4;
  logic [7:0] status4;

  int n_cmp = 0;
  int n_bad = 0;

  cu_param #(.RAW(3)) dut (
    .clk(clk), .reset_n(reset_n), .IR(IR), .N(N), .Z(Z), .C(C), .mem_rdy(mem_rdy), .go(go),
    .W_Adr(W_Adr), .R_Adr(R_Adr), .S_Adr(S_Adr), .adr_sel(adr_sel), .s_sel(s_sel),
    .pc_ld(pc_ld), .pc_inc(pc_inc), .pc_sel(pc_sel), .ir_ld(ir_ld), .mw_en(mw_en),
    .rw_en(rw_en), .alu_op(alu_op), .mem_req(mem_req), .halted(halted),
    .illegal(illegal), .status(status)
  );

  cu_param #(.RAW(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .IR(IR4), .N(N), .Z(Z), .C(C), .mem_rdy(mem_rdy), .go(go),
    .W_Adr(W4), .R_Adr(R4), .S_Adr(S4), .adr_sel(adr_sel4), .s_sel(s_sel4),
    .pc_ld(pc_ld4), .pc_inc(pc_inc4), .pc_sel(pc_sel4), .ir_ld(ir_ld4), .mw_en(mw_en4),
    .rw_en(rw_en4), .alu_op(alu_op4), .mem_req(mem_req4), .halted(halted4),
    .illegal(illegal4), .status(status4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic logic [31:0] obs();
    return {W_Adr, R_Adr, S_Adr, adr_sel, s_sel, pc_ld, pc_inc, pc_sel, ir_ld, mw_en, rw_en,
            alu_op, mem_req, halted, illegal, status};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    mem_rdy = 1'b0;
    go      = 1'b0;
    #2;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
  endtask

  // from FETCH: one ready fetch, then DECODE, landing in the state after DECODE
  task automatic goto_exec(input logic [15:0] ir);
    IR      = ir;
    mem_rdy = 1'b1;
    settle();
    cyc();
    mem_rdy = 1'b0;
    settle();
    cyc();
    settle();
  endtask

  // ---------------- reference model ----------------
  localparam int M_RESET = 0, M_FETCH = 1, M_DECODE = 2, M_EXEC = 3, M_HALT = 4, M_ILL = 5;

  int alu_tab  [16] = '{4, 5, 5, 0, 7, 6, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0};
  int rw_tab   [16] = '{1, 1, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
  int flag_tab [16] = '{1, 1, 1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};

  function automatic logic [31:0] model_out(input int ms, input logic [15:0] ir,
                                            input logic [2:0] f, input logic rdy);
    logic [2:0] w, r, s;
    logic adr, ss, pl, pi, ps, il, mw, rw, mr, h, ill;
    logic [3:0] alu, nib;
    logic [7:0] st;
    {w, r, s} = '0;
    {adr, ss, pl, pi, ps, il, mw, rw, mr, h, ill} = '0;
    alu = 4'd0;
    st  = 8'd0;
    nib = ir[12:9];
    case (ms)
      M_RESET:  st = 8'hFF;
      M_FETCH:  begin mr = 1; st = 8'h80; il = rdy; pi = rdy; end
      M_DECODE: st = 8'hC0;
      M_EXEC: begin
        st = {f, 1'b0, nib};
        w = ir[8:6]; r = ir[5:3]; s = ir[2:0];
        alu = 4'(alu_tab[nib]);
        rw  = rw_tab[nib] != 0;
        case (nib)
          4'h8: begin r = s; adr = 1; ss = 1; mr = 1; rw = rdy; end
          4'h9: begin r = w; adr = 1; mr = 1; mw = rdy; end
          4'hA: begin ss = 1; mr = 1; rw = rdy; pi = rdy; end
          4'hC: pl = f[1];
          4'hD: pl = ~f[1];
          4'hE: pl = f[0];
          4'hF: begin pl = 1; ps = 1; end
          default: ;
        endcase
      end
      M_HALT: begin h = 1; st = {f, 5'b01011}; end
      default: begin ill = 1; st = 8'hF0; end
    endcase
    return {w, r, s, adr, ss, pl, pi, ps, il, mw, rw, alu, mr, h, ill, st};
  endfunction

  function automatic int model_next(input int ms, input logic [15:0] ir, input logic rdy,
                                    input logic g);
    logic [3:0] nib;
    nib = ir[12:9];
    case (ms)
      M_RESET:  return M_FETCH;
      M_FETCH:  return rdy ? M_DECODE : M_FETCH;
      M_DECODE: return (ir[15:13] != 3'b111) ? M_ILL : (nib == 4'hB) ? M_HALT : M_EXEC;
      M_EXEC:   return (nib >= 4'h8 && nib <= 4'hA && !rdy) ? M_EXEC : M_FETCH;
      M_HALT:   return g ? M_FETCH : M_HALT;
      default:  return M_ILL;
    endcase
  endfunction

  // ---------------- opcode table ----------------
  typedef struct {
    logic [6:0] op;
    logic [3:0] alu;
    logic       rw;
    logic       pcld;
    logic       pcsel;
  } vec_t;

  vec_t tab[12];

  initial begin
    int ms;
    logic [2:0] mf;
    logic [31:0] exp;

    IR = 16'h0; IR4 = 19'h0; N = 0; Z = 0; C = 0; mem_rdy = 0; go = 0; reset_n = 0;

    tab[0]  = '{7'h70, 4'b0100, 1'b1, 1'b0, 1'b0};
    tab[1]  = '{7'h71, 4'b0101, 1'b1, 1'b0, 1'b0};
    tab[2]  = '{7'h72, 4'b0101, 1'b0, 1'b0, 1'b0};
    tab[3]  = '{7'h73, 4'b0000, 1'b1, 1'b0, 1'b0};
    tab[4]  = '{7'h74, 4'b0111, 1'b1, 1'b0, 1'b0};
    tab[5]  = '{7'h75, 4'b0110, 1'b1, 1'b0, 1'b0};
    tab[6]  = '{7'h76, 4'b0010, 1'b1, 1'b0, 1'b0};
    tab[7]  = '{7'h77, 4'b0011, 1'b1, 1'b0, 1'b0};
    tab[8]  = '{7'h7C, 4'b0000, 1'b0, 1'b0, 1'b0};
    tab[9]  = '{7'h7D, 4'b0000, 1'b0, 1'b1, 1'b0};
    tab[10] = '{7'h7E, 4'b0000, 1'b0, 1'b0, 1'b0};
    tab[11] = '{7'h7F, 4'b0000, 1'b0, 1'b1, 1'b1};

    // reset, including a reset asserted in the middle of FETCH
    do_reset();
    chk("reset_word", obs(), 32'h0000_00FF);
    cyc(); mem_rdy = 0; settle();
    chk("fetch_after_reset", obs(), 32'h0000_0480);
    reset_n = 0; #1;
    chk("reset_mid_fetch", obs(), 32'h0000_00FF);
    cyc();
    chk("reset_held", obs(), 32'h0000_00FF);
    reset_n = 1; #1;
    cyc(); settle();
    chk("fetch_after_release", obs(), 32'h0000_0480);

    // ADD with flags written from the datapath
    N = 0; Z = 1; C = 1;
    IR = 16'hE0D1; mem_rdy = 1; settle();
    chk("fetch_ready", 32'({mem_req, ir_ld, pc_inc, status}), 32'({3'b111, 8'h80}));
    cyc(); mem_rdy = 0; settle();
    chk("decode_word", obs(), 32'h0000_00C0);
    cyc(); settle();
    chk("add_exec", 32'({W_Adr, R_Adr, S_Adr, alu_op, rw_en, mw_en, mem_req, status}),
        32'({3'd3, 3'd2, 3'd1, 4'b0100, 1'b1, 1'b0, 1'b0, 8'h00}));
    cyc(); settle();
    chk("add_rw_one_cycle", 32'({rw_en, mem_req, status}), 32'({1'b0, 1'b1, 8'h80}));
    N = 0; Z = 0; C = 0;
    goto_exec(16'hE0D1);
    chk("add_flags_status", 32'(status), 32'h60);
    cyc();

    // LD with two wait states
    goto_exec(16'hF0C5);
    for (int i = 0; i < 3; i++) begin
      mem_rdy = (i == 2); settle();
      chk($sformatf("ld_wait%0d", i),
          32'({mem_req, rw_en, pc_inc, pc_ld, R_Adr, adr_sel, s_sel}),
          32'({1'b1, (i == 2), 1'b0, 1'b0, 3'd5, 1'b1, 1'b1}));
      cyc();
    end
    mem_rdy = 0; settle();
    chk("ld_done_fetch", 32'({mem_req, rw_en, status}), 32'({1'b1, 1'b0, 8'h80}));

    // branches with ps_Z=1
    N = 0; Z = 1; C = 0;
    goto_exec({7'h72, 9'o123});
    cyc();
    N = 1; Z = 0; C = 1;
    goto_exec({7'h7C, 9'o0});
    chk("je_taken", 32'({pc_ld, pc_sel, adr_sel, rw_en, status}), 32'({4'b1000, 8'h4C}));
    cyc();
    goto_exec({7'h7D, 9'o0});
    chk("jne_not_taken", 32'({pc_ld, pc_sel, adr_sel, rw_en, status}), 32'({4'b0000, 8'h4D}));
    cyc();

    // HALT and resume
    goto_exec({7'h7B, 9'o0});
    chk("halt_word", 32'({halted, mem_req, status}), 32'({1'b1, 1'b0, 8'h4B}));
    cyc(); settle();
    chk("halt_stays", 32'({halted, status}), 32'({1'b1, 8'h4B}));
    go = 1; settle(); cyc(); go = 0; settle();
    chk("resume_fetch", 32'({mem_req, halted, status}), 32'({1'b1, 1'b0, 8'h80}));

    // ILLEGAL is sticky despite go
    goto_exec(16'h0000);
    chk("illegal_word", obs(), 32'h0000_01F0);
    go = 1;
    for (int i = 0; i < 20; i++) begin
      mem_rdy = 1'($urandom);
      cyc();
      chk("illegal_sticky", 32'({illegal, pc_ld, mem_req, status}), 32'({3'b100, 8'hF0}));
    end
    go = 0;

    // RAW=4 build, 19-bit IR
    do_reset();
    IR4 = {7'h70, 4'd5, 4'd9, 4'd12};
    cyc();
    N = 1; Z = 0; C = 1;
    goto_exec(16'hE0D1);
    chk("raw4_add", 32'({W4, R4, S4, alu_op4, rw_en4, status4}),
        32'({4'd5, 4'd9, 4'd12, 4'b0100, 1'b1, 8'h00}));
    cyc();
    goto_exec(16'hE0D1);
    chk("raw4_flags", 32'(status4), 32'hA0);
    cyc();

    // opcode table with cleared flags
    do_reset();
    N = 0; Z = 0; C = 0;
    cyc();
    foreach (tab[i]) begin
      goto_exec({tab[i].op, 9'($urandom)});
      chk($sformatf("tab_op%h", tab[i].op),
          32'({alu_op, rw_en, pc_ld, pc_sel, mem_req, status}),
          32'({tab[i].alu, tab[i].rw, tab[i].pcld, tab[i].pcsel, 1'b0, 4'b0000, tab[i].op[3:0]}));
      cyc();
    end

    // random run against the reference model
    do_reset();
    ms = M_RESET;
    mf = 3'b000;
    for (int k = 0; k < 800; k++) begin
      if (ms == M_ILL && $urandom_range(0, 3) == 0) begin
        do_reset();
        ms = M_RESET;
        mf = 3'b000;
      end
      if (ms == M_FETCH) begin
        if ($urandom_range(0, 15) == 0) IR = {7'($urandom_range(0, 111)), 9'($urandom)};
        else                            IR = {3'b111, 4'($urandom_range(0, 15)), 9'($urandom)};
      end
      mem_rdy = 1'($urandom);
      go      = ($urandom_range(0, 3) == 0);
      {N, Z, C} = 3'($urandom);
      settle();
      exp = model_out(ms, IR, mf, mem_rdy);
      chk("random", obs(), exp);
      if (ms == M_EXEC && flag_tab[IR[12:9]] != 0 && IR[15:13] == 3'b111) mf = {N, Z, C};
      ms = model_next(ms, IR, mem_rdy, go);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
